seg_scan_arbiter: RTL

- Owns the 8-digit seven-segment display and time-shares it between two requesters, A (primary) and B (secondary).
- Each requester supplies a full 8-nibble hex value.
- The block arbitrates ownership on frame boundaries, latches the owner's value once per frame, and scans the digits with an inter-digit blanking gap to suppress ghosting.
- Sits between the application logic (counters, switch echo) and the board pins.

---
 rtl/seg_scan_if.sv | 32 +++
 rtl/seg_scan_arbiter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_if.sv
// seg_scan_if
//   Bundles the requester handshake and the display pins of seg_scan_arbiter.
//   master : the application side (drives requests and data, sees grants and pins)
//   slave  : the arbiter side
// Signals
//   req_a, req_b       level requests from requester A (primary) and B (secondary)
//   data_a, data_b     8-nibble hex values; nibble k is shown on digit k
//   grant_a, grant_b   current owner of the display (one-hot or both 0)
//   frame_done         one-cycle pulse in the last cycle of the digit-7 slot
//   led_en             digit enables, active-low, bit k = digit k
//   led_cx             segments {a,b,c,d,e,f,g,dp}, active-low
interface seg_scan_if;
  logic        req_a;
  logic [31:0] data_a;
  logic        req_b;
  logic [31:0] data_b;
  logic        grant_a;
  logic        grant_b;
  logic        frame_done;
  logic [7:0]  led_en;
  logic [7:0]  led_cx;

  modport master (
    output req_a, data_a, req_b, data_b,
    input  grant_a, grant_b, frame_done, led_en, led_cx
  );

  modport slave (
    input  req_a, data_a, req_b, data_b,
    output grant_a, grant_b, frame_done, led_en, led_cx
  );
endinterface

// File: rtl/seg_scan_arbiter.sv
// seg_scan_arbiter
//   Time-shares an 8-digit seven-segment display between requester A (primary)
//   and requester B (secondary). Ownership changes only on frame boundaries,
//   the owner's value is latched once per frame, and each digit slot starts
//   with a blanking gap to suppress ghosting.
// Ports
//   clk   system clock
//   clr   asynchronous active-high reset
//   bus   seg_scan_if.slave: requests/data in, grants, frame_done, led_en, led_cx out
// Parameters
//   SCAN_DIV     cycles per digit slot (4..2^20)
//   BLANK_CYC    blanked cycles at the start of each slot (< SCAN_DIV)
//   HOLD_FRAMES  minimum frames an owner keeps the display under contention (>= 1)
// Build option
//   SEG_LEADING_ZERO_BLANK_EN  blank digits above the most-significant non-zero
//                              nibble (digit 0 always shown)
//
// state    | meaning
// ---------+-----------------------------------------------
// ST_IDLE  | nobody owns the display, all digits dark
// ST_OWN_A | requester A owns the display, grant_a = 1
// ST_OWN_B | requester B owns the display, grant_b = 1
module seg_scan_arbiter #(
  parameter int SCAN_DIV    = 100000,
  parameter int BLANK_CYC   = 1000,
  parameter int HOLD_FRAMES = 500
) (
  input  logic       clk,
  input  logic       clr,
  seg_scan_if.slave  bus
);

  localparam int SLOT_W = $clog2(SCAN_DIV);
  localparam int FRM_W  = $clog2(HOLD_FRAMES + 1);

  localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(SCAN_DIV - 1);
  localparam logic [SLOT_W-1:0] SLOT_BLANK = SLOT_W'(BLANK_CYC);
  localparam logic [FRM_W-1:0]  FRM_HOLD   = FRM_W'(HOLD_FRAMES - 1);
  localparam logic [FRM_W-1:0]  FRM_MAX    = FRM_W'(HOLD_FRAMES);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN_A = 2'd1,
    ST_OWN_B = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [SLOT_W-1:0]  slot_cnt, slot_nxt;
  logic [2:0]         digit_idx, idx_nxt;
  logic [FRM_W-1:0]   frame_cnt, frm_nxt;
  logic [31:0]        latched, latch_nxt;
  logic               boundary;
  logic [3:0]         nib_nxt;
  logic [7:0]         en_nxt, cx_nxt;
  logic               fd_nxt;

  logic               grant_a_q, grant_b_q, frame_done_q;
  logic [7:0]         led_en_q, led_cx_q;

`ifdef SEG_LEADING_ZERO_BLANK_EN
  logic [2:0]         msd_nxt;
`endif

  // Segment order {a,b,c,d,e,f,g,dp}, active-low, dp always off.
  function automatic logic [7:0] hex_glyph(input logic [3:0] nib);
    logic [7:0] g;
    case (nib)
      4'h0: g = 8'h03;
      4'h1: g = 8'h9F;
      4'h2: g = 8'h25;
      4'h3: g = 8'h0D;
      4'h4: g = 8'h99;
      4'h5: g = 8'h49;
      4'h6: g = 8'h41;
      4'h7: g = 8'h1F;
      4'h8: g = 8'h01;
      4'h9: g = 8'h09;
      4'hA: g = 8'h11;
      4'hB: g = 8'hC1;
      4'hC: g = 8'h63;
      4'hD: g = 8'h85;
      4'hE: g = 8'h61;
      default: g = 8'h71;
    endcase
    return g;
  endfunction

  // The pins are decoded from the next-cycle counter/state values so that the
  // registered outputs line up exactly with the slot counter: blanking covers
  // slot cycles 0..BLANK_CYC-1 and a new owner shows from digit-0 cycle 0.
  always_comb begin
    boundary  = (digit_idx == 3'd7) && (slot_cnt == SLOT_LAST);

    slot_nxt  = slot_cnt + SLOT_W'(1);
    idx_nxt   = digit_idx;
    if (slot_cnt == SLOT_LAST) begin
      slot_nxt = '0;
      idx_nxt  = digit_idx + 3'd1;
    end

    state_nxt = state;
    frm_nxt   = frame_cnt;
    latch_nxt = latched;
    if (boundary) begin
      case (state)
        ST_IDLE: begin
          if (bus.req_a)      state_nxt = ST_OWN_A;
          else if (bus.req_b) state_nxt = ST_OWN_B;
        end
        ST_OWN_A: begin
          if (!bus.req_a)
            state_nxt = bus.req_b ? ST_OWN_B : ST_IDLE;
          else if (bus.req_b && (frame_cnt >= FRM_HOLD))
            state_nxt = ST_OWN_B;
        end
        ST_OWN_B: begin
          if (!bus.req_b)
            state_nxt = bus.req_a ? ST_OWN_A : ST_IDLE;
          else if (bus.req_a && (frame_cnt >= FRM_HOLD))
            state_nxt = ST_OWN_A;
        end
        default: state_nxt = ST_IDLE;
      endcase

      if (state_nxt != state)
        frm_nxt = '0;
      else if (frame_cnt != FRM_MAX)
        frm_nxt = frame_cnt + FRM_W'(1);

      case (state_nxt)
        ST_OWN_A: latch_nxt = bus.data_a;
        ST_OWN_B: latch_nxt = bus.data_b;
        default:  latch_nxt = 32'h0;
      endcase
    end

    nib_nxt = latch_nxt[{idx_nxt, 2'b00} +: 4];

    if ((state_nxt == ST_IDLE) || (slot_nxt < SLOT_BLANK))
      en_nxt = 8'hFF;
    else
      en_nxt = ~(8'b1 << idx_nxt);

    if (state_nxt == ST_IDLE)
      cx_nxt = 8'hFF;
    else
      cx_nxt = hex_glyph(nib_nxt);

`ifdef SEG_LEADING_ZERO_BLANK_EN
    msd_nxt = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (latch_nxt[k*4 +: 4] != 4'h0) msd_nxt = 3'(k);
    end
    if (idx_nxt > msd_nxt) cx_nxt = 8'hFF;
`endif

    fd_nxt = (idx_nxt == 3'd7) && (slot_nxt == SLOT_LAST);
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      slot_cnt     <= '0;
      digit_idx    <= 3'd0;
      frame_cnt    <= '0;
      state        <= ST_IDLE;
      latched      <= 32'h0;
      grant_a_q    <= 1'b0;
      grant_b_q    <= 1'b0;
      frame_done_q <= 1'b0;
      led_en_q     <= 8'hFF;
      led_cx_q     <= 8'hFF;
    end else begin
      slot_cnt     <= slot_nxt;
      digit_idx    <= idx_nxt;
      frame_cnt    <= frm_nxt;
      state        <= state_nxt;
      latched      <= latch_nxt;
      grant_a_q    <= (state_nxt == ST_OWN_A);
      grant_b_q    <= (state_nxt == ST_OWN_B);
      frame_done_q <= fd_nxt;
      led_en_q     <= en_nxt;
      led_cx_q     <= cx_nxt;
    end
  end

  assign bus.grant_a    = grant_a_q;
  assign bus.grant_b    = grant_b_q;
  assign bus.frame_done = frame_done_q;
  assign bus.led_en     = led_en_q;
  assign bus.led_cx     = led_cx_q;

endmodule
